mdu: RTL and testbench

Multiply/divide unit for the EX stage of the five-stage pipeline, next to the ALU. It takes forwarded rs/rt operands and runs mult, multu, div and divu over a fixed number of cycles, then commits the results to the HI/LO registers. It also performs mthi/mtlo writes and drives HI/LO for mfhi/mflo. Its `Busy` output feeds the hazard unit, which stalls any HI/LO-touching instruction that reaches EX while an operation is in flight.

---
 rtl/mdu.sv | 121 ++++++++++++
 tb/tb_mdu.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: multi-cycle mult/div committing to HI/LO,
// plus single-cycle mthi/mtlo. Busy is a registered view of the RUN state.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    input  logic        Start,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        state_dbg
);

    localparam int unsigned MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW    = (MAX_N < 2) ? 1 : $clog2(MAX_N + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [31:0]   p_hi, p_lo;
    logic          p_wr;

    logic          accept_md, is_div, commit;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   a_mag, b_mag, b_div, q_mag, r_mag;
    logic [31:0]   res_hi, res_lo;
    logic          neg_q, neg_r;

    // One unsigned divider serves both div and divu; signed div works on magnitudes
    // so the -2^31 / -1 case wraps to 0x80000000 instead of overflowing.
    always_comb begin
        is_div = (Op == OP_DIV) || (Op == OP_DIVU);
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        neg_q  = (Op == OP_DIV) && (A[31] ^ B[31]);
        neg_r  = (Op == OP_DIV) && A[31];
        a_mag  = ((Op == OP_DIV) && A[31]) ? (32'd0 - A) : A;
        b_mag  = ((Op == OP_DIV) && B[31]) ? (32'd0 - B) : B;
        b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (Op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                res_lo = neg_q ? (32'd0 - q_mag) : q_mag;
                res_hi = neg_r ? (32'd0 - r_mag) : r_mag;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx  = state;
        accept_md = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (Start && (Op >= OP_MULT) && (Op <= OP_DIVU)) begin
                    accept_md = 1'b1;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    commit   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            p_wr  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            state <= state_nx;
            if (accept_md) begin
                cnt  <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                p_hi <= res_hi;
                p_lo <= res_lo;
                // A zero divisor still runs the full latency but leaves HI/LO untouched.
                p_wr <= !(is_div && (B == 32'd0));
            end else if (state == RUN && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit && p_wr) begin
                HI <= p_hi;
                LO <= p_lo;
            end
            if (state == IDLE && Start && Op == OP_MTHI) HI <= A;
            if (state == IDLE && Start && Op == OP_MTLO) LO <= A;
        end
    end

    assign Busy      = (state == RUN);
    assign state_dbg = state;

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu: reset, mult/div arithmetic, latency, mthi/mtlo,
// ignored starts while running, and divide-by-zero hold behaviour.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  Op;
    logic        Start;
    logic [31:0] HI, LO;
    logic        Busy;
    logic        state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op), .Start(Start),
        .HI(HI), .LO(LO), .Busy(Busy), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div, count Busy cycles, confirm HI/LO held until commit.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0, lo0;
        int busy_n;
        logic held;
        hi0 = HI;
        lo0 = LO;
        A = a; B = b; Op = op; Start = 1'b1;
        tick();
        Start = 1'b0; Op = 3'd0;
        busy_n = 0;
        held = 1'b1;
        while (Busy && busy_n < 60) begin
            busy_n++;
            if (HI !== hi0 || LO !== lo0) held = 1'b0;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(n));
        check({tag, "_held"}, {31'd0, held}, 32'd1);
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        reset = 1'b0; A = '0; B = '0; Op = '0; Start = 1'b0;
        repeat (3) tick();
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_state", {31'd0, state_dbg}, 32'd0);
        reset = 1'b1;
        tick();

        // Reset mid-RUN abandons the mult entirely.
        A = 32'hFFFF_FFFE; B = 32'd3; Op = 3'd1; Start = 1'b1;
        tick();
        Start = 1'b0; Op = 3'd0;
        repeat (3) tick();
        check("midrun_busy_before", {31'd0, Busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrun_rst_busy", {31'd0, Busy}, 32'd0);
        check("midrun_rst_hi", HI, 32'd0);
        check("midrun_rst_lo", LO, 32'd0);
        tick();
        reset = 1'b1;
        repeat (10) tick();
        check("midrun_no_commit_hi", HI, 32'd0);
        check("midrun_no_commit_lo", LO, 32'd0);
        check("midrun_no_commit_busy", {31'd0, Busy}, 32'd0);

        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        // mthi then mtlo on consecutive cycles.
        A = 32'h1234_5678; Op = 3'd5; Start = 1'b1;
        tick();
        check("mthi_hi", HI, 32'h1234_5678);
        check("mthi_lo", LO, 32'h8000_0000);
        check("mthi_busy", {31'd0, Busy}, 32'd0);
        A = 32'h9ABC_DEF0; Op = 3'd6;
        tick();
        Start = 1'b0; Op = 3'd0;
        check("mtlo_lo", LO, 32'h9ABC_DEF0);
        check("mtlo_hi", HI, 32'h1234_5678);
        check("mtlo_busy", {31'd0, Busy}, 32'd0);

        // Starts during RUN (mtlo at cycle 2, multu at the commit edge) are ignored.
        A = 32'hFFFF_FFFE; B = 32'd3; Op = 3'd1; Start = 1'b1;
        tick();
        Start = 1'b0; Op = 3'd0;
        tick();
        A = 32'hDEAD_BEEF; Op = 3'd6; Start = 1'b1;
        tick();
        Start = 1'b0; Op = 3'd0;
        check("ign_mtlo_lo", LO, 32'h9ABC_DEF0);
        check("ign_mtlo_busy", {31'd0, Busy}, 32'd1);
        tick();
        tick();
        check("ign_pre_commit_busy", {31'd0, Busy}, 32'd1);
        A = 32'd7; B = 32'd9; Op = 3'd2; Start = 1'b1;
        tick();
        Start = 1'b0; Op = 3'd0;
        check("ign_commit_busy", {31'd0, Busy}, 32'd0);
        check("ign_commit_hi", HI, 32'hFFFF_FFFF);
        check("ign_commit_lo", LO, 32'hFFFF_FFFA);
        repeat (6) tick();
        check("ign_after_busy", {31'd0, Busy}, 32'd0);
        check("ign_after_hi", HI, 32'hFFFF_FFFF);
        check("ign_after_lo", LO, 32'hFFFF_FFFA);

        // Divide by zero keeps the preloaded HI/LO.
        A = 32'h11; Op = 3'd5; Start = 1'b1;
        tick();
        A = 32'h22; Op = 3'd6;
        tick();
        Start = 1'b0; Op = 3'd0;
        run_op("div0", 3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        run_op("divu0", 3'd4, 32'hFFFF_FFFF, 32'd0, 10, 32'h11, 32'h22);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
